// File: rtl/can_pkg.sv
// Shared definitions for the CAN transmit path: scheduler state encoding,
// mailbox geometry and retry counter sizing.
package can_pkg;

  localparam int ID_W_DEF = 11;
  localparam int NUM_MB   = 3;
  localparam int SEL_W    = 2;
  localparam int RETRY_W  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUS = 2'd1,
    ACTIVE   = 2'd2,
    LOST     = 2'd3
  } txState_e;

  function automatic logic [NUM_MB-1:0] selOneHot(input logic [SEL_W-1:0] sel);
    selOneHot = NUM_MB'(1) << sel;
  endfunction

endpackage

// File: rtl/id_priority_arbiter.sv
// Combinational mailbox selector: the pending mailbox with the lowest
// identifier wins, ties go to the lowest mailbox index.
module id_priority_arbiter
  import can_pkg::*;
#(
  parameter int ID_W = ID_W_DEF
) (
  input  logic [NUM_MB-1:0] req,
  input  logic [ID_W-1:0]   id0,
  input  logic [ID_W-1:0]   id1,
  input  logic [ID_W-1:0]   id2,
  output logic [SEL_W-1:0]  winIdx,
  output logic              winValid
);

  logic [ID_W-1:0] ids [NUM_MB];
  logic [ID_W-1:0] bestId;

  assign ids[0] = id0;
  assign ids[1] = id1;
  assign ids[2] = id2;

  // Strict less-than keeps the earlier (lower) index on equal ids.
  always_comb begin
    winIdx   = '0;
    winValid = 1'b0;
    bestId   = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (req[i] && (!winValid || ids[i] < bestId)) begin
        winValid = 1'b1;
        winIdx   = SEL_W'(i);
        bestId   = ids[i];
      end
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// CAN transmit scheduler: picks the highest-priority mailbox, launches frames
// at bus-idle / foreign SOF, and handles arbitration loss and error retries.
module tx_scheduler
  import can_pkg::*;
#(
  parameter int MAX_RETRY = 8,
  parameter int ID_W      = ID_W_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                samplePoint,
  input  logic                busIdle,
  input  logic                isStart,
  input  logic [NUM_MB-1:0]   req,
  input  logic [ID_W-1:0]     id0,
  input  logic [ID_W-1:0]     id1,
  input  logic [ID_W-1:0]     id2,
  input  logic                txDone,
  input  logic                txError,
  input  logic                arbLost,
  output logic                txStart,
  output logic [SEL_W-1:0]    txSel,
  output logic                txBusy,
  output logic [NUM_MB-1:0]   txAck,
  output logic [NUM_MB-1:0]   txAbort,
  output logic [RETRY_W-1:0]  retryCnt,
  output logic [1:0]          dbgState
);

  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

  txState_e           state;
  logic [SEL_W-1:0]   winIdx;
  logic               winValid;
  logic [RETRY_W-1:0] nextCnt;

  id_priority_arbiter #(.ID_W(ID_W)) u_arb (
    .req      (req),
    .id0      (id0),
    .id1      (id1),
    .id2      (id2),
    .winIdx   (winIdx),
    .winValid (winValid)
  );

  assign nextCnt  = (retryCnt == '1) ? retryCnt : retryCnt + 1'b1;
  assign dbgState = state;

  // Handshake: req[i] is a level held by the host until txAck[i] or txAbort[i]
  // pulses for one cycle; the host must drop req[i] on seeing that pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      txStart  <= 1'b0;
      txSel    <= '0;
      txBusy   <= 1'b0;
      txAck    <= '0;
      txAbort  <= '0;
      retryCnt <= '0;
    end else begin
      txStart <= 1'b0;
      txAck   <= '0;
      txAbort <= '0;
      if (samplePoint) begin
        case (state)
          IDLE: begin
            if (|req) state <= WAIT_BUS;
          end
          WAIT_BUS: begin
            if (!winValid) begin
              state    <= IDLE;
              retryCnt <= '0;
            end else begin
              // Retries belong to the mailbox last latched in txSel.
              if (winIdx != txSel) retryCnt <= '0;
              if (busIdle || isStart) begin
                txStart <= 1'b1;
                txSel   <= winIdx;
                txBusy  <= 1'b1;
                state   <= ACTIVE;
              end
            end
          end
          ACTIVE: begin
            if (txError) begin
              txBusy <= 1'b0;
              if (nextCnt == MAX_R) begin
                txAbort  <= selOneHot(txSel);
                retryCnt <= '0;
                state    <= IDLE;
              end else begin
                retryCnt <= nextCnt;
                state    <= WAIT_BUS;
              end
            end else if (txDone) begin
              txAck    <= selOneHot(txSel);
              retryCnt <= '0;
              txBusy   <= 1'b0;
              state    <= IDLE;
            end else if (arbLost) begin
              txBusy <= 1'b0;
              state  <= LOST;
            end
          end
          LOST: begin
            if (busIdle) state <= WAIT_BUS;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter MAX_RETRY, default 8, maximum error-triggered retransmissions before a request is aborted (1..15).
REQ-002 Parameter ID_W, default 11, identifier width (standard CAN frame).
REQ-003 clock  input  1  single system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 samplePoint  input  1  one-cycle strobe per CAN bit; state advances only in cycles where samplePoint=1, except reset.
REQ-006 busIdle  input  1  interframe-space detector reports bus idle (intermission complete).
REQ-007 isStart  input  1  interframe-space detector reports a foreign start-of-frame.
REQ-008 req  input  3  per-mailbox transmit request, level, held until txAck or txAbort.
REQ-009 id0, id1, id2  input  ID_W each  identifier of mailbox 0/1/2; stable while the corresponding req=1.
REQ-010 txDone, txError, arbLost  input  1 each  one-cycle frame-engine status pulses, sampled on samplePoint cycles.
REQ-011 txStart  output  1  one-cycle pulse commanding the frame engine to emit SOF.
REQ-012 txSel  output  2  index of granted mailbox; valid while txBusy=1.
REQ-013 txBusy  output  1  a frame of this node is in flight.
REQ-014 txAck, txAbort  output  3 each  one-hot one-cycle pulses: success / retry limit exhausted for mailbox i.
REQ-015 retryCnt  output  4  error retries consumed by the current request.

Function
REQ-016 States: IDLE, WAIT_BUS, ACTIVE, LOST; encoding from the shared package.
REQ-017 Winner = pending mailbox with numerically lowest id; equal ids resolved by lowest index.
REQ-018 IDLE: any req=1 at samplePoint -> WAIT_BUS; else stay.
REQ-019 WAIT_BUS: winner recomputed every samplePoint; if req=0 for all -> IDLE, retryCnt cleared.
REQ-020 WAIT_BUS: at samplePoint with busIdle=1 or isStart=1 -> txStart=1 one cycle later (registered), txSel latched to winner, txBusy=1, -> ACTIVE.
REQ-021 txSel frozen while ACTIVE; req changes during ACTIVE are ignored until frame completion.
REQ-022 ACTIVE, txDone: txAck[txSel] pulse, retryCnt cleared, txBusy=0, -> IDLE.
REQ-023 ACTIVE, arbLost: txBusy=0, -> LOST; retryCnt unchanged (arbitration loss is not a retry).
REQ-024 ACTIVE, txError: retryCnt+1; if new value = MAX_RETRY, txAbort[txSel] pulse, retryCnt cleared, -> IDLE; else -> WAIT_BUS.
REQ-025 Simultaneous status pulses: txError overrides txDone and arbLost; txDone overrides arbLost.
REQ-026 LOST: wait for busIdle=1 at samplePoint (foreign frame finished), then -> WAIT_BUS; isStart in LOST ignored.
REQ-027 retryCnt belongs to the latched mailbox; if the winner changes in WAIT_BUS after an error, retryCnt cleared.
REQ-028 txAck and txAbort never asserted in the same cycle; at most one bit of each set.
REQ-029 retryCnt saturates, never wraps; MAX_RETRY=1 aborts on first error.

Reset
REQ-030 reset_n=0 forces IDLE, txStart=0, txSel=0, txBusy=0, txAck=0, txAbort=0, retryCnt=0 immediately, including mid-frame.
REQ-031 After release, first state change occurs no earlier than the first samplePoint cycle.

Structure
REQ-032 Package can_pkg holds state encoding, ID_W default, mailbox count (3), retry counter width.
REQ-033 One sub-module id_priority_arbiter: combinational lowest-id/lowest-index selector returning index and valid.

Verification
REQ-034 req=001, id0=0x123, busIdle=1 at samplePoint -> txStart pulse, txSel=0; txDone -> txAck=001, state IDLE.
REQ-035 req=111, ids 0x200/0x100/0x100 -> txSel=1 (tie by index); after txAck, next grant txSel=2.
REQ-036 Granted mailbox 0, arbLost -> txBusy=0, no txStart until busIdle=1, then retransmit with retryCnt=0.
REQ-037 MAX_RETRY=3, three txError pulses -> retryCnt 1,2, then txAbort=001, retryCnt=0, IDLE.
REQ-038 txDone and txError same cycle -> retryCnt+1, no txAck; reset_n low in ACTIVE -> all outputs 0 same cycle.
